// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if
// -----------------
// Bundles every signal of the ALU issue controller except clock and reset:
//   - issue handshake   : in_valid, in_ready, instr, rs_data, rt_data
//   - ALU drive side    : alu_S, alu_T, alu_FS, alu_shamt (controller -> ALU)
//   - ALU response      : alu_Y, alu_C, alu_V (ALU -> controller)
//   - result handshake  : res_valid, res_ready, res_Y, res_C, res_V, res_dest,
//                         illegal, ovf_trap
//   - status            : op_count
// Modports:
//   slave  - the controller itself (alu_issue_ctrl)
//   master - its environment: register-read stage, the ALU, and writeback
interface alu_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    logic [31:0] alu_S;
    logic [31:0] alu_T;
    logic [4:0]  alu_FS;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_Y;
    logic        alu_C;
    logic        alu_V;

    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_Y;
    logic        res_C;
    logic        res_V;
    logic [4:0]  res_dest;
    logic        illegal;
    logic        ovf_trap;
    logic [15:0] op_count;

    modport slave (
        input  in_valid, instr, rs_data, rt_data,
        input  alu_Y, alu_C, alu_V,
        input  res_ready,
        output in_ready,
        output alu_S, alu_T, alu_FS, alu_shamt,
        output res_valid, res_Y, res_C, res_V, res_dest, illegal, ovf_trap,
        output op_count
    );

    modport master (
        output in_valid, instr, rs_data, rt_data,
        output alu_Y, alu_C, alu_V,
        output res_ready,
        input  in_ready,
        input  alu_S, alu_T, alu_FS, alu_shamt,
        input  res_valid, res_Y, res_C, res_V, res_dest, illegal, ovf_trap,
        input  op_count
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// --------------
// Multi-cycle issue controller for the integer ALU. Accepts one MIPS
// instruction plus its register operands, decodes it into ALU function
// select / operands / shift amount, waits one cycle for the ALU, captures
// Y/C/V and returns a tagged result with writeback index.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high reset
//   bus    - alu_issue_ctrl_if.slave: issue handshake, ALU drive/response,
//            result handshake, illegal/ovf_trap flags, op_count
//
// Build option:
//   ALU_ISSUE_TRAP_EN - when defined, add/addi/sub results with signed
//   overflow raise ovf_trap and suppress the writeback (res_dest = 0).
//   When undefined ovf_trap is always 0.
module alu_issue_ctrl (
    input  logic            clk,
    input  logic            reset,
    alu_issue_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [4:0] FS_NONE = 5'h00;
    localparam logic [4:0] FS_ADD  = 5'h02;
    localparam logic [4:0] FS_ADDU = 5'h03;
    localparam logic [4:0] FS_SUB  = 5'h04;
    localparam logic [4:0] FS_SUBU = 5'h05;
    localparam logic [4:0] FS_SLT  = 5'h06;
    localparam logic [4:0] FS_SLTU = 5'h07;
    localparam logic [4:0] FS_AND  = 5'h08;
    localparam logic [4:0] FS_OR   = 5'h09;
    localparam logic [4:0] FS_XOR  = 5'h0A;
    localparam logic [4:0] FS_NOR  = 5'h0B;
    localparam logic [4:0] FS_SLL  = 5'h0C;
    localparam logic [4:0] FS_SRL  = 5'h0D;
    localparam logic [4:0] FS_SRA  = 5'h0E;
    localparam logic [4:0] FS_ANDI = 5'h16;
    localparam logic [4:0] FS_ORI  = 5'h17;
    localparam logic [4:0] FS_XORI = 5'h18;
    localparam logic [4:0] FS_LUI  = 5'h19;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        resp_done;
    logic        trap_hit;
    logic [4:0]  issue_dest;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    logic        dec_legal;
    logic [4:0]  dec_fs;
    logic [31:0] dec_s;
    logic [31:0] dec_t;
    logic [4:0]  dec_shamt;
    logic [4:0]  dec_dest;

    assign opcode   = bus.instr[31:26];
    assign funct    = bus.instr[5:0];
    assign imm      = bus.instr[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0000, imm};

    // Instruction decode. R-type writes rd, I-type writes rt. Shifts take
    // their operand from rt and force S to zero; lui feeds the raw immediate
    // on T with S zero and lets the ALU place it in the upper half.
    always_comb begin
        dec_legal = 1'b1;
        dec_fs    = FS_NONE;
        dec_s     = bus.rs_data;
        dec_t     = bus.rt_data;
        dec_shamt = 5'd0;
        dec_dest  = bus.instr[15:11];
        if (opcode == OP_RTYPE) begin
            case (funct)
                6'h20: dec_fs = FS_ADD;
                6'h21: dec_fs = FS_ADDU;
                6'h22: dec_fs = FS_SUB;
                6'h23: dec_fs = FS_SUBU;
                6'h24: dec_fs = FS_AND;
                6'h25: dec_fs = FS_OR;
                6'h26: dec_fs = FS_XOR;
                6'h27: dec_fs = FS_NOR;
                6'h2A: dec_fs = FS_SLT;
                6'h2B: dec_fs = FS_SLTU;
                6'h00: begin
                    dec_fs    = FS_SLL;
                    dec_s     = 32'h0;
                    dec_shamt = bus.instr[10:6];
                end
                6'h02: begin
                    dec_fs    = FS_SRL;
                    dec_s     = 32'h0;
                    dec_shamt = bus.instr[10:6];
                end
                6'h03: begin
                    dec_fs    = FS_SRA;
                    dec_s     = 32'h0;
                    dec_shamt = bus.instr[10:6];
                end
                default: dec_legal = 1'b0;
            endcase
        end else begin
            dec_dest = bus.instr[20:16];
            dec_t    = imm_sext;
            case (opcode)
                6'h08: dec_fs = FS_ADD;
                6'h09: dec_fs = FS_ADDU;
                6'h0A: dec_fs = FS_SLT;
                6'h0B: dec_fs = FS_SLTU;
                6'h0C: begin
                    dec_fs = FS_ANDI;
                    dec_t  = imm_zext;
                end
                6'h0D: begin
                    dec_fs = FS_ORI;
                    dec_t  = imm_zext;
                end
                6'h0E: begin
                    dec_fs = FS_XORI;
                    dec_t  = imm_zext;
                end
                6'h0F: begin
                    dec_fs = FS_LUI;
                    dec_s  = 32'h0;
                    dec_t  = imm_zext;
                end
                default: dec_legal = 1'b0;
            endcase
        end
    end

    // Overflow trap looks at the operation still held on alu_FS during EXEC
    // and the overflow flag the ALU reports for it.
`ifdef ALU_ISSUE_TRAP_EN
    assign trap_hit = ((bus.alu_FS == FS_ADD) || (bus.alu_FS == FS_SUB)) && bus.alu_V;
`else
    assign trap_hit = 1'b0;
`endif

    // in_ready is gated by reset so upstream never sees a ready controller
    // while reset is still asserted.
    assign bus.in_ready  = (state == IDLE) && !reset;
    assign bus.res_valid = (state == RESP);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Illegal instructions skip EXEC because there is
    // nothing for the ALU to compute; their result is synthesised directly.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        resp_done = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = dec_legal ? EXEC : RESP;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (bus.res_ready) begin
                    resp_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ALU drive registers, result capture and the completion counter.
    // The alu_* registers only change when a legal instruction is issued,
    // so they keep presenting the last issued operation while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.alu_S     <= 32'h0;
            bus.alu_T     <= 32'h0;
            bus.alu_FS    <= FS_NONE;
            bus.alu_shamt <= 5'd0;
            issue_dest    <= 5'd0;
            bus.res_Y     <= 32'h0;
            bus.res_C     <= 1'b0;
            bus.res_V     <= 1'b0;
            bus.res_dest  <= 5'd0;
            bus.illegal   <= 1'b0;
            bus.ovf_trap  <= 1'b0;
            bus.op_count  <= 16'h0;
        end else begin
            if (accept) begin
                if (dec_legal) begin
                    bus.alu_S     <= dec_s;
                    bus.alu_T     <= dec_t;
                    bus.alu_FS    <= dec_fs;
                    bus.alu_shamt <= dec_shamt;
                    issue_dest    <= dec_dest;
                end else begin
                    bus.res_Y    <= 32'h0;
                    bus.res_C    <= 1'b0;
                    bus.res_V    <= 1'b0;
                    bus.res_dest <= 5'd0;
                    bus.illegal  <= 1'b1;
                    bus.ovf_trap <= 1'b0;
                end
            end
            if (state == EXEC) begin
                bus.res_Y    <= bus.alu_Y;
                bus.res_C    <= bus.alu_C;
                bus.res_V    <= bus.alu_V;
                bus.res_dest <= trap_hit ? 5'd0 : issue_dest;
                bus.illegal  <= 1'b0;
                bus.ovf_trap <= trap_hit;
            end
            if (resp_done) begin
                bus.op_count <= bus.op_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
// -----------------
// Bench for alu_issue_ctrl with a behavioural ALU attached. Directed table
// vectors, hand-written reset sequences and random instructions checked
// against an instruction-level reference model. Honours ALU_ISSUE_TRAP_EN.
module tb_alu_issue_ctrl;

`ifdef ALU_ISSUE_TRAP_EN
    localparam bit TRAP_BUILD = 1'b1;
`else
    localparam bit TRAP_BUILD = 1'b0;
`endif

    localparam longint MAX_S32 = 64'sd2147483647;
    localparam longint MIN_S32 = -64'sd2147483648;

    typedef struct {
        logic        legal;
        logic [4:0]  fs;
        logic [31:0] s;
        logic [31:0] t;
        logic [4:0]  shamt;
        logic [31:0] y;
        logic        c;
        logic        v;
        logic [4:0]  dest;
        logic        trap;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        int          stall;
        exp_t        e;
    } vec_t;

    logic clk;
    logic reset;
    alu_issue_ctrl_if bus();

    int errCount;
    int checkCount;
    int expOpCount;
    vec_t vecs[$];
    logic [32:0] aluWide;

    alu_issue_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The attached ALU: purely combinational from the controller's drive
    // registers, flags produced the way a carry-chain ALU would.
    always_comb begin
        aluWide    = 33'h0;
        bus.alu_Y  = 32'h0;
        bus.alu_C  = 1'b0;
        bus.alu_V  = 1'b0;
        case (bus.alu_FS)
            5'h02, 5'h03: begin
                aluWide   = {1'b0, bus.alu_S} + {1'b0, bus.alu_T};
                bus.alu_Y = aluWide[31:0];
                bus.alu_C = aluWide[32];
                bus.alu_V = (bus.alu_S[31] == bus.alu_T[31]) && (aluWide[31] != bus.alu_S[31]);
            end
            5'h04, 5'h05: begin
                aluWide   = {1'b0, bus.alu_S} + {1'b0, ~bus.alu_T} + 33'd1;
                bus.alu_Y = aluWide[31:0];
                bus.alu_C = aluWide[32];
                bus.alu_V = (bus.alu_S[31] != bus.alu_T[31]) && (aluWide[31] != bus.alu_S[31]);
            end
            5'h06: bus.alu_Y = {31'h0, $signed(bus.alu_S) < $signed(bus.alu_T)};
            5'h07: bus.alu_Y = {31'h0, bus.alu_S < bus.alu_T};
            5'h08, 5'h16: bus.alu_Y = bus.alu_S & bus.alu_T;
            5'h09, 5'h17: bus.alu_Y = bus.alu_S | bus.alu_T;
            5'h0A, 5'h18: bus.alu_Y = bus.alu_S ^ bus.alu_T;
            5'h0B: bus.alu_Y = ~(bus.alu_S | bus.alu_T);
            5'h0C: bus.alu_Y = bus.alu_T << bus.alu_shamt;
            5'h0D: bus.alu_Y = bus.alu_T >> bus.alu_shamt;
            5'h0E: bus.alu_Y = $signed(bus.alu_T) >>> bus.alu_shamt;
            5'h19: bus.alu_Y = {bus.alu_T[15:0], 16'h0000};
            default: bus.alu_Y = 32'h0;
        endcase
    end

    // Single comparison point: counts every check and reports failures.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    function automatic exp_t mkExp(input logic legal, input logic [4:0] fs, input logic [31:0] s,
                                   input logic [31:0] t, input logic [4:0] shamt, input logic [31:0] y,
                                   input logic c, input logic v, input logic [4:0] dest, input logic trap);
        exp_t e;
        e.legal = legal; e.fs = fs; e.s = s; e.t = t; e.shamt = shamt;
        e.y = y; e.c = c; e.v = v; e.dest = dest; e.trap = trap;
        return e;
    endfunction

    task automatic addVec(input string name, input logic [31:0] ins, input logic [31:0] rs,
                          input logic [31:0] rt, input int stall, input exp_t e);
        vec_t v;
        v.name = name; v.instr = ins; v.rs = rs; v.rt = rt; v.stall = stall; v.e = e;
        vecs.push_back(v);
    endtask

    // Reference model: what the MIPS instruction means, in plain arithmetic.
    function automatic exp_t refModel(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        exp_t e;
        logic [5:0] op;
        logic [5:0] fn;
        logic [15:0] imm;
        logic [4:0] sh;
        bit addLike;
        bit subLike;
        bit trapable;
        longint sum;
        op = ins[31:26]; fn = ins[5:0]; imm = ins[15:0]; sh = ins[10:6];
        addLike = 0; subLike = 0; trapable = 0;
        e = mkExp(1'b1, 5'h00, rs, rt, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        if (op == 6'h00) begin
            e.dest = ins[15:11];
            case (fn)
                6'h20: begin e.fs = 5'h02; e.y = rs + rt; addLike = 1; trapable = 1; end
                6'h21: begin e.fs = 5'h03; e.y = rs + rt; addLike = 1; end
                6'h22: begin e.fs = 5'h04; e.y = rs - rt; subLike = 1; trapable = 1; end
                6'h23: begin e.fs = 5'h05; e.y = rs - rt; subLike = 1; end
                6'h24: begin e.fs = 5'h08; e.y = rs & rt; end
                6'h25: begin e.fs = 5'h09; e.y = rs | rt; end
                6'h26: begin e.fs = 5'h0A; e.y = rs ^ rt; end
                6'h27: begin e.fs = 5'h0B; e.y = ~(rs | rt); end
                6'h2A: begin e.fs = 5'h06; e.y = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0; end
                6'h2B: begin e.fs = 5'h07; e.y = (rs < rt) ? 32'd1 : 32'd0; end
                6'h00: begin e.fs = 5'h0C; e.s = 32'h0; e.shamt = sh; e.y = rt << sh; end
                6'h02: begin e.fs = 5'h0D; e.s = 32'h0; e.shamt = sh; e.y = rt >> sh; end
                6'h03: begin e.fs = 5'h0E; e.s = 32'h0; e.shamt = sh; e.y = $signed(rt) >>> sh; end
                default: e.legal = 1'b0;
            endcase
        end else begin
            e.dest = ins[20:16];
            e.t = {{16{imm[15]}}, imm};
            case (op)
                6'h08: begin e.fs = 5'h02; e.y = rs + e.t; addLike = 1; trapable = 1; end
                6'h09: begin e.fs = 5'h03; e.y = rs + e.t; addLike = 1; end
                6'h0A: begin e.fs = 5'h06; e.y = ($signed(rs) < $signed(e.t)) ? 32'd1 : 32'd0; end
                6'h0B: begin e.fs = 5'h07; e.y = (rs < e.t) ? 32'd1 : 32'd0; end
                6'h0C: begin e.fs = 5'h16; e.t = {16'h0, imm}; e.y = rs & e.t; end
                6'h0D: begin e.fs = 5'h17; e.t = {16'h0, imm}; e.y = rs | e.t; end
                6'h0E: begin e.fs = 5'h18; e.t = {16'h0, imm}; e.y = rs ^ e.t; end
                6'h0F: begin e.fs = 5'h19; e.s = 32'h0; e.t = {16'h0, imm}; e.y = {imm, 16'h0000}; end
                default: e.legal = 1'b0;
            endcase
        end
        if (addLike) begin
            e.c = (longint'(rs) + longint'(e.t)) >= 64'sh1_0000_0000;
            sum = longint'($signed(rs)) + longint'($signed(e.t));
            e.v = (sum > MAX_S32) || (sum < MIN_S32);
        end
        if (subLike) begin
            e.c = (rs >= e.t);
            sum = longint'($signed(rs)) - longint'($signed(e.t));
            e.v = (sum > MAX_S32) || (sum < MIN_S32);
        end
        e.trap = TRAP_BUILD && trapable && e.v;
        if (e.trap) e.dest = 5'd0;
        if (!e.legal) begin
            e.y = 32'h0; e.c = 1'b0; e.v = 1'b0; e.dest = 5'd0; e.trap = 1'b0;
        end
        return e;
    endfunction

    // One full transaction: issue, check ALU drive during EXEC, measure
    // latency, check the result, optionally stall, then hand it off.
    // With noise set, in_valid/res_ready are waved while they must be ignored.
    task automatic applyStimulus(input string name, input logic [31:0] ins, input logic [31:0] rs,
                                 input logic [31:0] rt, input int stall, input bit noise, input exp_t e);
        int waitCnt;
        int lat;
        logic [31:0] heldY;
        waitCnt = 0;
        while (!bus.in_ready && waitCnt < 20) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        checkOutput({name, ".in_ready_idle"}, {31'h0, bus.in_ready}, 32'd1);
        bus.instr = ins; bus.rs_data = rs; bus.rt_data = rt; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = noise;
        bus.instr     = $urandom;
        bus.rs_data   = $urandom;
        bus.rt_data   = $urandom;
        bus.res_ready = noise && e.legal;
        lat = 1;
        if (e.legal) begin
            checkOutput({name, ".alu_FS"}, {27'h0, bus.alu_FS}, {27'h0, e.fs});
            checkOutput({name, ".alu_S"}, bus.alu_S, e.s);
            checkOutput({name, ".alu_T"}, bus.alu_T, e.t);
            checkOutput({name, ".alu_shamt"}, {27'h0, bus.alu_shamt}, {27'h0, e.shamt});
            checkOutput({name, ".in_ready_busy"}, {31'h0, bus.in_ready}, 32'd0);
        end
        while (!bus.res_valid && lat < 8) begin
            @(posedge clk); #1;
            bus.res_ready = 1'b0;
            lat++;
        end
        bus.res_ready = 1'b0;
        checkOutput({name, ".latency"}, lat, e.legal ? 32'd2 : 32'd1);
        checkOutput({name, ".res_Y"}, bus.res_Y, e.y);
        checkOutput({name, ".res_C"}, {31'h0, bus.res_C}, {31'h0, e.c});
        checkOutput({name, ".res_V"}, {31'h0, bus.res_V}, {31'h0, e.v});
        checkOutput({name, ".res_dest"}, {27'h0, bus.res_dest}, {27'h0, e.dest});
        checkOutput({name, ".illegal"}, {31'h0, bus.illegal}, {31'h0, !e.legal});
        checkOutput({name, ".ovf_trap"}, {31'h0, bus.ovf_trap}, {31'h0, e.trap});
        heldY = bus.res_Y;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            checkOutput({name, ".stall_valid"}, {31'h0, bus.res_valid}, 32'd1);
            checkOutput({name, ".stall_Y"}, bus.res_Y, heldY);
            checkOutput({name, ".stall_in_ready"}, {31'h0, bus.in_ready}, 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        expOpCount++;
        checkOutput({name, ".op_count"}, {16'h0, bus.op_count}, expOpCount);
        checkOutput({name, ".res_valid_drop"}, {31'h0, bus.res_valid}, 32'd0);
        checkOutput({name, ".in_ready_back"}, {31'h0, bus.in_ready}, 32'd1);
    endtask

    function automatic logic [31:0] pickData();
        case ($urandom_range(0, 5))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h00000000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] randInstr();
        logic [31:0] ins;
        int k;
        ins = $urandom;
        k = $urandom_range(0, 16);
        if (k < 8) begin
            ins[31:26] = 6'h00;
            case ($urandom_range(0, 14))
                0: ins[5:0] = 6'h20;  1: ins[5:0] = 6'h21;  2: ins[5:0] = 6'h22;
                3: ins[5:0] = 6'h23;  4: ins[5:0] = 6'h24;  5: ins[5:0] = 6'h25;
                6: ins[5:0] = 6'h26;  7: ins[5:0] = 6'h27;  8: ins[5:0] = 6'h2A;
                9: ins[5:0] = 6'h2B;  10: ins[5:0] = 6'h00; 11: ins[5:0] = 6'h02;
                12: ins[5:0] = 6'h03; 13: ins[5:0] = 6'h01;
                default: ins[5:0] = 6'($urandom);
            endcase
        end else if (k < 16) begin
            ins[31:26] = 6'(k);
        end else begin
            ins[31:26] = 6'($urandom);
        end
        return ins;
    endfunction

    // Watchdog so a stuck design still ends the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        int seen;
        exp_t illegalExp;
        exp_t re;
        logic [31:0] ins;
        logic [31:0] rs;
        logic [31:0] rt;

        errCount = 0; checkCount = 0; expOpCount = 0;
        illegalExp = mkExp(1'b0, 5'h00, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);

        addVec("sll",       32'h000B5100, 32'h12345678, 32'h0000000F, 0, mkExp(1, 5'h0C, 32'h0, 32'h0000000F, 5'd4, 32'h000000F0, 0, 0, 5'd10, 0));
        addVec("lui",       32'h3C081234, 32'hDEADBEEF, 32'h55555555, 0, mkExp(1, 5'h19, 32'h0, 32'h00001234, 5'd0, 32'h12340000, 0, 0, 5'd8, 0));
        addVec("ori",       32'h3508FFFF, 32'h12340000, 32'h00000000, 0, mkExp(1, 5'h17, 32'h12340000, 32'h0000FFFF, 5'd0, 32'h1234FFFF, 0, 0, 5'd8, 0));
        addVec("addi_ovf",  32'h21090001, 32'h7FFFFFFF, 32'hAAAAAAAA, 0, mkExp(1, 5'h02, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 0, 1, TRAP_BUILD ? 5'd0 : 5'd9, TRAP_BUILD));
        addVec("add_stall", 32'h01098020, 32'h00000005, 32'h00000007, 5, mkExp(1, 5'h02, 32'h5, 32'h7, 5'd0, 32'h0000000C, 0, 0, 5'd16, 0));
        addVec("opc_3f",    32'hFC000000, 32'h11111111, 32'h22222222, 1, illegalExp);
        addVec("sub",       32'h01098822, 32'h00000003, 32'h00000005, 0, mkExp(1, 5'h04, 32'h3, 32'h5, 5'd0, 32'hFFFFFFFE, 0, 0, 5'd17, 0));
        addVec("slt",       32'h0109502A, 32'hFFFFFFFF, 32'h00000001, 0, mkExp(1, 5'h06, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h00000001, 0, 0, 5'd10, 0));
        addVec("sra",       32'h000B5203, 32'h00000000, 32'h80000000, 0, mkExp(1, 5'h0E, 32'h0, 32'h80000000, 5'd8, 32'hFF800000, 0, 0, 5'd10, 0));
        addVec("srl31",     32'h000B57C2, 32'h0000FFFF, 32'h80000000, 0, mkExp(1, 5'h0D, 32'h0, 32'h80000000, 5'd31, 32'h00000001, 0, 0, 5'd10, 0));
        addVec("andi",      32'h31098000, 32'hFFFFFFFF, 32'h00000000, 0, mkExp(1, 5'h16, 32'hFFFFFFFF, 32'h00008000, 5'd0, 32'h00008000, 0, 0, 5'd9, 0));
        addVec("nor",       32'h01095027, 32'h0F0F0F0F, 32'h00FF00FF, 0, mkExp(1, 5'h0B, 32'h0F0F0F0F, 32'h00FF00FF, 5'd0, 32'hF000F000, 0, 0, 5'd10, 0));
        addVec("addiu_neg", 32'h2509FFFF, 32'h00000000, 32'h00000000, 0, mkExp(1, 5'h03, 32'h0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 0, 0, 5'd9, 0));
        addVec("bad_funct", 32'h00000001, 32'h00000000, 32'h00000000, 0, illegalExp);
        addVec("sub_ovf",   32'h01098822, 32'h80000000, 32'h00000001, 0, mkExp(1, 5'h04, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 1, 1, TRAP_BUILD ? 5'd0 : 5'd17, TRAP_BUILD));
        addVec("addu_carry", 32'h01098021, 32'hFFFFFFFF, 32'h00000001, 0, mkExp(1, 5'h03, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h00000000, 1, 0, 5'd16, 0));
        addVec("sltiu",     32'h2D09FFFF, 32'h00000005, 32'h00000000, 0, mkExp(1, 5'h07, 32'h5, 32'hFFFFFFFF, 5'd0, 32'h00000001, 0, 0, 5'd9, 0));

        bus.in_valid = 1'b0; bus.res_ready = 1'b0;
        bus.instr = 32'h0; bus.rs_data = 32'h0; bus.rt_data = 32'h0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.in_ready", {31'h0, bus.in_ready}, 32'd0);
        checkOutput("rst.res_valid", {31'h0, bus.res_valid}, 32'd0);
        checkOutput("rst.illegal", {31'h0, bus.illegal}, 32'd0);
        checkOutput("rst.ovf_trap", {31'h0, bus.ovf_trap}, 32'd0);
        checkOutput("rst.op_count", {16'h0, bus.op_count}, 32'd0);
        checkOutput("rst.alu_FS", {27'h0, bus.alu_FS}, 32'd0);
        checkOutput("rst.alu_S", bus.alu_S, 32'd0);
        checkOutput("rst.alu_T", bus.alu_T, 32'd0);
        checkOutput("rst.alu_shamt", {27'h0, bus.alu_shamt}, 32'd0);
        checkOutput("rst.res_Y", bus.res_Y, 32'd0);
        checkOutput("rst.res_CV", {30'h0, bus.res_C, bus.res_V}, 32'd0);
        checkOutput("rst.res_dest", {27'h0, bus.res_dest}, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("rst.in_ready_after", {31'h0, bus.in_ready}, 32'd1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].name, vecs[i].instr, vecs[i].rs, vecs[i].rt, vecs[i].stall, (i % 2) == 1, vecs[i].e);
        end

        // Reset in the middle of EXEC: the add in flight must vanish.
        @(posedge clk); #1;
        bus.instr = 32'h01098020; bus.rs_data = 32'h5; bus.rt_data = 32'h7; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        reset = 1'b1;
        #2;
        checkOutput("rstexec.in_ready", {31'h0, bus.in_ready}, 32'd0);
        checkOutput("rstexec.res_valid", {31'h0, bus.res_valid}, 32'd0);
        checkOutput("rstexec.op_count", {16'h0, bus.op_count}, 32'd0);
        checkOutput("rstexec.alu_FS", {27'h0, bus.alu_FS}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        expOpCount = 0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (bus.res_valid) seen++;
        end
        checkOutput("rstexec.no_result", seen, 32'd0);
        checkOutput("rstexec.in_ready_back", {31'h0, bus.in_ready}, 32'd1);
        checkOutput("rstexec.op_count_after", {16'h0, bus.op_count}, 32'd0);

        // Reset while an illegal result is waiting in RESP.
        applyStimulus("post_rst_add", 32'h01098020, 32'h5, 32'h7, 0, 1'b0,
                      mkExp(1, 5'h02, 32'h5, 32'h7, 5'd0, 32'h0000000C, 0, 0, 5'd16, 0));
        bus.instr = 32'hFC000000; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checkOutput("rstresp.res_valid_before", {31'h0, bus.res_valid}, 32'd1);
        reset = 1'b1;
        #2;
        checkOutput("rstresp.res_valid", {31'h0, bus.res_valid}, 32'd0);
        checkOutput("rstresp.illegal", {31'h0, bus.illegal}, 32'd0);
        checkOutput("rstresp.op_count", {16'h0, bus.op_count}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        expOpCount = 0;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (bus.res_valid) seen++;
        end
        checkOutput("rstresp.no_result", seen, 32'd0);

        // Random instructions against the reference model.
        for (int n = 0; n < 300; n++) begin
            ins = randInstr();
            rs = pickData();
            rt = pickData();
            re = refModel(ins, rs, rt);
            applyStimulus($sformatf("rand%0d", n), ins, rs, rt, $urandom_range(0, 2), 1'($urandom_range(0, 1)), re);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
